// File: rtl/fifo_sync_pkg.sv
// Shared sizing helpers and status-flag bundle for the single-clock FWFT FIFO.
// FIFO_PROG_FLAGS_EN (see fifo_sync) enables the programmable flags and data_count.
package fifo_sync_pkg;

    // Cycles the write/read sides stay busy after reset is released.
    localparam int RST_BUSY_CYCLES = 2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fifo_status_t;

    localparam fifo_status_t STATUS_RESET = '{full: 1'b0, almost_full: 1'b0,
                                              empty: 1'b1, almost_empty: 1'b0};

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// No reset on the array or the read register so it maps onto block RAM.
module fifo_sync_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8192,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with registered status flags and handshake pulses.
// Define FIFO_PROG_FLAGS_EN to build prog_full/prog_empty/data_count; otherwise they are constants.
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    WRITE_DEPTH       = 8192,
    parameter int                    PROG_FULL_THRESH  = 10,
    parameter int                    PROG_EMPTY_THRESH = 10,
    parameter logic [DATA_WIDTH-1:0] DOUT_RESET_VALUE  = '0,
    localparam int                   AW                = ptr_w(WRITE_DEPTH),
    localparam int                   CNT_W             = cnt_w(WRITE_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  data_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  wr_rst_busy,
    output logic                  rd_rst_busy,
    output logic                  prog_full,
    output logic                  prog_empty,
    output logic [CNT_W-1:0]      data_count
);

    typedef logic [AW-1:0] ptr_t;

    ptr_t                  wr_ptr_reg;
    ptr_t                  rd_ptr_reg;
    ptr_t                  rd_ptr_next;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    fifo_status_t          status_reg;
    fifo_status_t          status_next;
    logic [1:0]            busy_cnt_reg;
    logic                  busy;
    logic                  do_write;
    logic                  do_read;
    logic                  wr_ack_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  bypass_reg;
    logic [DATA_WIDTH-1:0] bypass_data_reg;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign busy        = (busy_cnt_reg != 2'd0);
    assign do_write    = wr_en && !status_reg.full && !busy;
    assign do_read     = rd_en && !status_reg.empty && !busy;
    assign rd_ptr_next = do_read ? rd_ptr_reg + ptr_t'(1) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_write, do_read})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
        status_next.full         = (count_next == CNT_W'(WRITE_DEPTH));
        status_next.almost_full  = (count_next == CNT_W'(WRITE_DEPTH - 1));
        status_next.empty        = (count_next == CNT_W'(0));
        status_next.almost_empty = (count_next == CNT_W'(1));
    end

    // The RAM always reads the address that will be the head after this edge. When that
    // address is being written at the same edge, the RAM returns stale data, so din is
    // captured and presented instead for one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            status_reg      <= STATUS_RESET;
            busy_cnt_reg    <= 2'(RST_BUSY_CYCLES);
            wr_ack_reg      <= 1'b0;
            overflow_reg    <= 1'b0;
            underflow_reg   <= 1'b0;
            bypass_reg      <= 1'b0;
            bypass_data_reg <= DOUT_RESET_VALUE;
        end else begin
            if (busy) begin
                busy_cnt_reg <= busy_cnt_reg - 2'd1;
            end
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_t'(1);
            end
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            status_reg      <= status_next;
            wr_ack_reg      <= do_write;
            overflow_reg    <= wr_en && status_reg.full && !busy;
            underflow_reg   <= rd_en && status_reg.empty && !busy;
            bypass_reg      <= do_write && (rd_ptr_next == wr_ptr_reg);
            bypass_data_reg <= din;
        end
    end

    fifo_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (WRITE_DEPTH)
    ) u_ram (
        .clk_i (clk_i),
        .we    (do_write),
        .waddr (wr_ptr_reg),
        .wdata (din),
        .raddr (rd_ptr_next),
        .rdata (ram_rdata)
    );

    assign dout         = status_reg.empty ? DOUT_RESET_VALUE
                        : (bypass_reg ? bypass_data_reg : ram_rdata);
    assign full         = status_reg.full;
    assign almost_full  = status_reg.almost_full;
    assign empty        = status_reg.empty;
    assign almost_empty = status_reg.almost_empty;
    assign data_valid   = !status_reg.empty;
    assign wr_ack       = wr_ack_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
    assign wr_rst_busy  = busy;
    assign rd_rst_busy  = busy;

`ifdef FIFO_PROG_FLAGS_EN
    logic prog_full_reg;
    logic prog_empty_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prog_full_reg  <= 1'b0;
            prog_empty_reg <= 1'b1;
        end else begin
            prog_full_reg  <= (count_next >= CNT_W'(PROG_FULL_THRESH));
            prog_empty_reg <= (count_next <= CNT_W'(PROG_EMPTY_THRESH));
        end
    end

    assign prog_full  = prog_full_reg;
    assign prog_empty = prog_empty_reg;
    assign data_count = count_reg;
`else
    assign prog_full  = 1'b0;
    assign prog_empty = 1'b1;
    assign data_count = '0;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: reset/busy, FWFT latency, fill/overflow/drain, underflow,
// same-cycle read+write, and mid-operation reset. Prog flags checked per FIFO_PROG_FLAGS_EN.
module tb_fifo_sync;

    localparam int DW    = 32;
    localparam int DEPTH = 8192;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          full, almost_full, empty, almost_empty, data_valid;
    logic          wr_ack, overflow, underflow, wr_rst_busy, rd_rst_busy;
    logic          prog_full, prog_empty;
    logic [CW-1:0] data_count;

    int total  = 0;
    int passed = 0;
    logic [DW-1:0] model_q[$];

    fifo_sync dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .data_valid   (data_valid),
        .wr_ack       (wr_ack),
        .overflow     (overflow),
        .underflow    (underflow),
        .wr_rst_busy  (wr_rst_busy),
        .rd_rst_busy  (rd_rst_busy),
        .prog_full    (prog_full),
        .prog_empty   (prog_empty),
        .data_count   (data_count)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst_ni = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = '0;

        // Reset held for 5 cycles
        repeat (5) tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_wr_busy", 32'(wr_rst_busy), 32'd1);
        chk("rst_rd_busy", 32'(rd_rst_busy), 32'd1);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_almost_empty", 32'(almost_empty), 32'd0);
        chk("rst_count", 32'(data_count), 32'd0);

        // Release; writes during the 2 busy cycles are ignored
        rst_ni = 1'b1;
        wr_en  = 1'b1;
        din    = 32'h77;
        tick();
        chk("busy1", 32'(wr_rst_busy), 32'd1);
        chk("busy1_empty", 32'(empty), 32'd1);
        tick();
        chk("busy2", 32'(rd_rst_busy), 32'd0);
        chk("busy2_empty", 32'(empty), 32'd1);
        chk("busy2_wr_ack", 32'(wr_ack), 32'd0);
        wr_en = 1'b0;
        tick();
        chk("idle_empty", 32'(empty), 32'd1);

        // Single word: FWFT visible one edge after the write
        wr_en = 1'b1;
        din   = 32'hA5;
        tick();
        wr_en = 1'b0;
        chk("a5_wr_ack", 32'(wr_ack), 32'd1);
        chk("a5_empty", 32'(empty), 32'd0);
        chk("a5_valid", 32'(data_valid), 32'd1);
        chk("a5_dout", dout, 32'hA5);
        chk("a5_almost_empty", 32'(almost_empty), 32'd1);
`ifdef FIFO_PROG_FLAGS_EN
        chk("a5_count", 32'(data_count), 32'd1);
`endif
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("a5_pop_empty", 32'(empty), 32'd1);
        chk("a5_pop_dout", dout, 32'd0);
        chk("a5_pop_wr_ack", 32'(wr_ack), 32'd0);
        chk("a5_pop_underflow", 32'(underflow), 32'd0);

        // Underflow
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("uf_flag", 32'(underflow), 32'd1);
        chk("uf_dout", dout, 32'd0);
        chk("uf_empty", 32'(empty), 32'd1);
        chk("uf_count", 32'(data_count), 32'd0);
        tick();
        chk("uf_clear", 32'(underflow), 32'd0);

        // Fill to full with 0..DEPTH-1
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1;
            din   = 32'(i);
            tick();
            if (i == 0) chk("fill_head", dout, 32'd0);
            if (i == 8) chk("fill9_prog_full", 32'(prog_full), 32'd0);
`ifdef FIFO_PROG_FLAGS_EN
            if (i == 9) chk("fill10_prog_full", 32'(prog_full), 32'd1);
            if (i == 9) chk("fill10_prog_empty", 32'(prog_empty), 32'd1);
            if (i == 10) chk("fill11_prog_empty", 32'(prog_empty), 32'd0);
            if (i == 10) chk("fill11_count", 32'(data_count), 32'd11);
`else
            if (i == 10) chk("fill11_prog_empty", 32'(prog_empty), 32'd1);
            if (i == 10) chk("fill11_count", 32'(data_count), 32'd0);
`endif
            if (i == DEPTH - 2) chk("fill_af_almost_full", 32'(almost_full), 32'd1);
            if (i == DEPTH - 2) chk("fill_af_full", 32'(full), 32'd0);
        end
        chk("full_flag", 32'(full), 32'd1);
        chk("full_almost_full", 32'(almost_full), 32'd0);
        chk("full_wr_ack", 32'(wr_ack), 32'd1);

        // Extra write while full is dropped
        din = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        chk("of_flag", 32'(overflow), 32'd1);
        chk("of_wr_ack", 32'(wr_ack), 32'd0);
        chk("of_full", 32'(full), 32'd1);
        chk("of_head", dout, 32'd0);

        // Read+write while full: read performed, write still rejected
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 32'hBEEF;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("fullrw_overflow", 32'(overflow), 32'd1);
        chk("fullrw_full", 32'(full), 32'd0);
        chk("fullrw_almost_full", 32'(almost_full), 32'd1);

        // Drain: remaining 1..DEPTH-1 in order
        for (int i = 1; i < DEPTH; i++) begin
            chk("drain_dout", dout, 32'(i));
            if (i == DEPTH - 1) chk("drain_almost_empty", 32'(almost_empty), 32'd1);
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_dout_reset", dout, 32'd0);

        // Read+write at count 1: new head is the word written this edge
        wr_en = 1'b1;
        din   = 32'h11;
        tick();
        din   = 32'h22;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("c1rw_dout", dout, 32'h22);
        chk("c1rw_wr_ack", 32'(wr_ack), 32'd1);
        chk("c1rw_empty", 32'(empty), 32'd0);
        tick();
        rd_en = 1'b0;
        chk("c1rw_pop_empty", 32'(empty), 32'd1);

        // Read+write into empty: write lands, read underflows
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 32'h33;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("e_rw_underflow", 32'(underflow), 32'd1);
        chk("e_rw_wr_ack", 32'(wr_ack), 32'd1);
        chk("e_rw_dout", dout, 32'h33);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("e_rw_pop_empty", 32'(empty), 32'd1);

        // 100 cycles of simultaneous read+write at count 5
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            din   = 32'(10 + i);
            model_q.push_back(din);
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 100; k++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            din   = 32'(100 + k);
            model_q.push_back(din);
            void'(model_q.pop_front());
            tick();
            chk("rw100_dout", dout, model_q[0]);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("rw100_wr_ack", 32'(wr_ack), 32'd1);
        chk("rw100_underflow", 32'(underflow), 32'd0);
`ifdef FIFO_PROG_FLAGS_EN
        chk("rw100_count", 32'(data_count), 32'd5);
`endif
        for (int i = 0; i < 5; i++) begin
            chk("rw100_drain", dout, 32'(195 + i));
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("rw100_final_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-operation discards contents
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            din   = 32'h50 + 32'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("pre_mrst_dout", dout, 32'h50);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mrst_async_empty", 32'(empty), 32'd1);
        chk("mrst_async_dout", dout, 32'd0);
        chk("mrst_async_busy", 32'(wr_rst_busy), 32'd1);
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        chk("mrst_busy_clear", 32'(wr_rst_busy), 32'd0);
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_valid", 32'(data_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
